// File: rtl/fetch_queue_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_queue_decode
// Purpose  : RV32I fetch/decode front end. Owns the fetch PC, reads a
//            combinational instruction ROM one word per cycle, buffers
//            {pc, instr} pairs in a DEPTH-entry circular queue and decodes
//            the head entry (register/opcode fields, immediate type and
//            sign-extended immediate) behind a valid/ready handshake.
//            A redirect flushes the queue and reloads the fetch PC.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            imem_addr/imem_rd  - instruction ROM address / read data
//            redirect/_pc       - flush and new fetch target (word aligned)
//            out_valid/ready    - downstream handshake
//            out_pc/out_instr   - presented entry
//            op funct3 funct7 rs1 rs2 rd ImmSrc ImmOp - decoded fields
//            count              - occupied queue entries
// Options  : FETCH_BYPASS_EN    - when defined, an empty queue presents the
//            word currently being fetched combinationally (0-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_decode #(
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    PC_WIDTH      = 32,
    parameter int                    DEPTH         = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [PC_WIDTH-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]       imem_rd,
    input  logic                        redirect,
    input  logic [PC_WIDTH-1:0]         redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PC_WIDTH-1:0]         out_pc,
    output logic [DATA_WIDTH-1:0]       out_instr,
    output logic [6:0]                  op,
    output logic [2:0]                  funct3,
    output logic [6:0]                  funct7,
    output logic [ADDRESS_WIDTH-1:0]    rs1,
    output logic [ADDRESS_WIDTH-1:0]    rs2,
    output logic [ADDRESS_WIDTH-1:0]    rd,
    output logic [2:0]                  ImmSrc,
    output logic [DATA_WIDTH-1:0]       ImmOp,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

    localparam logic [2:0] c_imm_i = 3'd0;
    localparam logic [2:0] c_imm_s = 3'd1;
    localparam logic [2:0] c_imm_b = 3'd2;
    localparam logic [2:0] c_imm_u = 3'd3;
    localparam logic [2:0] c_imm_j = 3'd4;

    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_q_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_instr [DEPTH];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_bypass;
    logic                  w_valid;
    logic [PC_WIDTH-1:0]   w_pres_pc;
    logic [DATA_WIDTH-1:0] w_pres_instr;
    logic                  w_pop;
    logic                  w_q_pop;
    logic                  w_fetch;
    logic                  w_push;

    assign imem_addr = r_pc;
    assign count     = r_count;

    // ------------------------------------------------------------------------
    // Presentation: queue head, or (bypass build) the word being fetched now
    // ------------------------------------------------------------------------
`ifdef FETCH_BYPASS_EN
    assign w_bypass     = (r_count == '0) && !redirect && !rst;
    assign w_valid      = (r_count != '0) || w_bypass;
    assign w_pres_pc    = w_bypass ? r_pc    : r_q_pc[r_rd_ptr];
    assign w_pres_instr = w_bypass ? imem_rd : r_q_instr[r_rd_ptr];
`else
    assign w_bypass     = 1'b0;
    assign w_valid      = (r_count != '0);
    assign w_pres_pc    = r_q_pc[r_rd_ptr];
    assign w_pres_instr = r_q_instr[r_rd_ptr];
`endif

    // Zeroing the presented entry when invalid makes every decode output 0
    // (opcode 0 decodes as I-type with a zero immediate).
    assign out_valid = w_valid;
    assign out_pc    = w_valid ? w_pres_pc    : '0;
    assign out_instr = w_valid ? w_pres_instr : '0;

    // ------------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------------
    assign w_pop   = w_valid && out_ready;
    // An accepted bypass word never entered the queue, so it is not popped.
    assign w_q_pop = w_pop && !w_bypass;
    // The fetch PC advances whenever the fetched word is consumed, either by
    // landing in the queue or by being accepted directly through the bypass.
    assign w_fetch = !redirect && ((r_count != c_full) || w_pop);
    assign w_push  = w_fetch && !(w_bypass && w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            // Masking keeps all redirect_pc bits in use while word-aligning.
            r_pc     <= redirect_pc & ~PC_WIDTH'(3);
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fetch) begin
                r_pc <= r_pc + PC_WIDTH'(4);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_q_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_q_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_pc;
            r_q_instr[r_wr_ptr] <= imem_rd;
        end
    end

    // ------------------------------------------------------------------------
    // Decode of the presented instruction
    // ------------------------------------------------------------------------
    assign op     = out_instr[6:0];
    assign funct3 = out_instr[14:12];
    assign funct7 = out_instr[31:25];
    assign rs1    = ADDRESS_WIDTH'(out_instr[19:15]);
    assign rs2    = ADDRESS_WIDTH'(out_instr[24:20]);
    assign rd     = ADDRESS_WIDTH'(out_instr[11:7]);

    always_comb begin
        ImmSrc = c_imm_i;
        case (out_instr[6:0])
            7'b0100011: ImmSrc = c_imm_s;
            7'b1100011: ImmSrc = c_imm_b;
            7'b0110111,
            7'b0010111: ImmSrc = c_imm_u;
            7'b1101111: ImmSrc = c_imm_j;
            default:    ImmSrc = c_imm_i;
        endcase
    end

    always_comb begin
        ImmOp = '0;
        case (ImmSrc)
            c_imm_s: ImmOp = {{(DATA_WIDTH-12){out_instr[31]}},
                              out_instr[31:25], out_instr[11:7]};
            c_imm_b: ImmOp = {{(DATA_WIDTH-13){out_instr[31]}},
                              out_instr[31], out_instr[7],
                              out_instr[30:25], out_instr[11:8], 1'b0};
            c_imm_u: ImmOp = {out_instr[31:12], 12'b0};
            c_imm_j: ImmOp = {{(DATA_WIDTH-21){out_instr[31]}},
                              out_instr[31], out_instr[19:12],
                              out_instr[20], out_instr[30:21], 1'b0};
            default: ImmOp = {{(DATA_WIDTH-12){out_instr[31]}},
                              out_instr[31:20]};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_decode
// Purpose  : Self-checking bench for fetch_queue_decode: directed scenarios
//            followed by randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_decode;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rd, redirect_pc, out_pc, out_instr, ImmOp;
    logic        redirect, out_valid, out_ready;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3, ImmSrc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue_decode #(
        .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .PC_WIDTH(32),
        .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .op(op), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmSrc(ImmSrc), .ImmOp(ImmOp),
        .count(count)
    );

    // Instruction ROM: either one constant word or a 256-word random table.
    logic        rom_mode;
    logic [31:0] rom_const;
    logic [31:0] rom [256];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return rom_mode ? rom[a[9:2]] : rom_const;
    endfunction

    always_comb imem_rd = rom_word(imem_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Holds reset for two cycles and releases it on a falling edge.
    task automatic reset_seq(input logic ready);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = ready;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Immediate type and value straight from the RV32I encoding rules.
    function automatic void ref_decode(input logic [31:0] w,
                                       output logic [2:0] src, output logic [31:0] imm);
        int v;
        case (w[6:0])
            7'b0100011: begin src = 3'd1; v = $signed({w[31:25], w[11:7]}); end
            7'b1100011: begin src = 3'd2;
                v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); end
            7'b0110111, 7'b0010111: begin src = 3'd3; v = {w[31:12], 12'h000}; end
            7'b1101111: begin src = 3'd4;
                v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); end
            default:    begin src = 3'd0; v = $signed(w[31:20]); end
        endcase
        imm = v;
    endfunction

    typedef struct {
        logic [31:0] w;
        logic [2:0]  src;
        logic [31:0] imm;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } dec_vec_t;

    dec_vec_t dvec [3];

    logic [63:0] m_q [$];
    logic [31:0] m_pc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  opsel [8];
        logic [31:0] w, e_pc, e_in, e_imm, rpc, base;
        logic [2:0]  e_src;
        logic        byp, e_valid, pop, adv;

        rom_mode  = 1'b0;
        rom_const = 32'h00100093;   // addi x1, x0, 1
        redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // ---- reset state, then fill with out_ready low ----
        rst = 1'b1;
        tick(); tick();
        #1;
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_immop", ImmOp, 0);
        check("rst_outpc", out_pc, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("fill_count", count, 4);
        check("fill_addr", imem_addr, 32'h10);
        check("fill_outpc", out_pc, 0);
        check("fill_immsrc", ImmSrc, 0);
        check("fill_immop", ImmOp, 1);
        check("fill_rd", rd, 1);
        tick();
        #1;
        check("full_hold_addr", imem_addr, 32'h10);
        check("full_hold_count", count, 4);

        // ---- full queue drained at one per cycle ----
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_flow_pc", out_pc, 32'(4 * i));
            check("full_flow_count", count, 4);
            check("full_flow_addr", imem_addr, 32'(16 + 4 * i));
            tick();
        end

        // ---- first-valid latency and streaming after reset ----
        reset_seq(1'b1);
        #1;
`ifdef FETCH_BYPASS_EN
        check("lat_valid0", out_valid, 1);
        check("lat_pc0", out_pc, 0);
        base = 32'h4;
`else
        check("lat_valid0", out_valid, 0);
        base = 32'h0;
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, base + 32'(4 * i));
        end

        // ---- redirect with three entries queued ----
        reset_seq(1'b0);
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("redir_pre_count", count, 3);
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        #1;
        check("redir_count", count, 0);
        check("redir_addr", imem_addr, 32'h100);
`ifdef FETCH_BYPASS_EN
        check("redir_valid", out_valid, 1);
        check("redir_outpc", out_pc, 32'h100);
`else
        check("redir_valid", out_valid, 0);
        tick();
        #1;
        check("redir_valid2", out_valid, 1);
        check("redir_outpc", out_pc, 32'h100);
`endif

        // ---- reset mid-operation ----
        reset_seq(1'b0);
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("midrst_pre_count", count, 3);
        out_ready = 1'b1; rst = 1'b1;
        tick();
        #1;
        check("midrst_count", count, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_addr", imem_addr, 0);
        rst = 1'b0;

        // ---- immediate decode vectors ----
        dvec[0] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 5'd0, 5'd0};
        dvec[1] = '{32'h00512423, 3'd1, 32'h00000008, 5'd2, 5'd5};
        dvec[2] = '{32'h123450B7, 3'd3, 32'h12345000, 5'd8, 5'd3};
        for (int i = 0; i < 3; i++) begin
            rom_const = dvec[i].w;
            reset_seq(1'b0);
            tick();
            #1;
            check("dec_immsrc", ImmSrc, dvec[i].src);
            check("dec_immop", ImmOp, dvec[i].imm);
            check("dec_rs1", rs1, dvec[i].r1);
            check("dec_rs2", rs2, dvec[i].r2);
        end

        // ---- randomized traffic against the queue model ----
        opsel = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
        for (int i = 0; i < 256; i++) begin
            w = $urandom();
            w[6:0] = opsel[$urandom_range(0, 7)];
            rom[i] = w;
        end
        rom_mode = 1'b1;
        reset_seq(1'b0);
        m_q.delete();
        m_pc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            redirect  = ($urandom_range(0, 15) == 0);
            rpc       = $urandom();
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            redirect_pc = rpc;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            byp = 1'b0;
`ifdef FETCH_BYPASS_EN
            byp = (m_q.size() == 0) && !redirect && !rst;
`endif
            e_pc = 32'h0; e_in = 32'h0;
            if (byp) begin
                e_pc = m_pc; e_in = rom_word(m_pc);
            end else if (m_q.size() != 0) begin
                e_pc = m_q[0][63:32]; e_in = m_q[0][31:0];
            end
            e_valid = byp || (m_q.size() != 0);
            ref_decode(e_in, e_src, e_imm);
            check("rnd_valid", out_valid, e_valid);
            check("rnd_count", count, m_q.size());
            check("rnd_addr", imem_addr, m_pc);
            check("rnd_outpc", out_pc, e_pc);
            check("rnd_instr", out_instr, e_in);
            check("rnd_fields", {funct7, rs2, rs1, funct3, rd, op}, e_in);
            check("rnd_immsrc", ImmSrc, e_src);
            check("rnd_immop", ImmOp, e_imm);

            if (rst) begin
                m_q.delete();
                m_pc = 32'h0;
            end else if (redirect) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                pop = e_valid && out_ready;
                adv = (m_q.size() < DEPTH) || pop;
                if (pop && !byp) void'(m_q.pop_front());
                if (adv && !(byp && pop)) m_q.push_back({m_pc, rom_word(m_pc)});
                if (adv) m_pc = m_pc + 32'h4;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
